// File: rtl/cacheline_adaptor_pkg.sv
// Shared types for the cacheline adaptor: FSM state encoding and beat-count constants.
package cacheline_adaptor_types;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int BEATS = 4;
  localparam int CNT_W = $clog2(BEATS);

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Line-side (arbiter) and burst-side (physical memory) signals of the cacheline adaptor.
interface cacheline_adaptor_if #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);

  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one whole-cacheline read/write from the arbiter into a 4-beat memory burst,
// reassembling read beats into line_o and serialising write lines onto burst_o.
module cacheline_adaptor
  import cacheline_adaptor_types::*;
#(
  parameter int LINE_W   = 256,
  parameter int BURST_W  = 64,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_buf_q;
  logic [LINE_W-1:0]   line_o_q;
  logic [LINE_W-1:0]   line_merged;
  logic [ADDR_W-1:0]   addr_q;
  logic                read_q, write_q, resp_q;
  logic                latch_rd, latch_wr, capture, finish_rd;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_rd    = 1'b0;
    latch_wr    = 1'b0;
    capture     = 1'b0;
    finish_rd   = 1'b0;
    // Line buffer with the incoming beat spliced in; the final read beat goes
    // straight to line_o from here so it never lags a cycle behind.
    line_merged = line_buf_q;
    line_merged[int'(cnt_q)*BURST_W +: BURST_W] = bus.burst_i;

    case (state_q)
      IDLE: begin
        if (bus.read_i) begin
          state_d  = RD_BURST;
          latch_rd = 1'b1;
        end else if (bus.write_i) begin
          state_d  = WR_BURST;
          latch_wr = 1'b1;
        end
      end
      RD_BURST: begin
        if (bus.resp_i) begin
          capture = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d   = DONE;
            finish_rd = 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      resp_q     <= 1'b0;
      addr_q     <= '0;
      line_buf_q <= '0;
      line_o_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      read_q  <= (state_d == RD_BURST);
      write_q <= (state_d == WR_BURST);
      resp_q  <= (state_d == DONE);
      if (latch_rd || latch_wr) addr_q <= bus.address_i & ~OFFSET_MASK;
      if (latch_wr)     line_buf_q <= bus.line_i;
      else if (capture) line_buf_q <= line_merged;
      if (finish_rd)    line_o_q   <= line_merged;
    end
  end

  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.line_o    = line_o_q;
  assign bus.burst_o   = write_q ? line_buf_q[int'(cnt_q)*BURST_W +: BURST_W] : '0;

  // Simultaneous requests are a system-level error; the read is serviced regardless.
  a_no_dual_request : assert property (
    @(posedge clk) disable iff (rst)
      (state_q == IDLE) |-> !(bus.read_i && bus.write_i)
  ) else $warning("cacheline_adaptor: read_i and write_i both high in IDLE, servicing read");

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: directed read/write bursts with gaps, back-to-back,
// asynchronous reset mid-burst, stray memory strobes and simultaneous requests.
module tb_cacheline_adaptor;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t        exp_q[$];
  logic [63:0] beat_q[$];
  logic [255:0] last_rd_line;

  cacheline_adaptor_if #(.ADDR_W(32), .LINE_W(256), .BURST_W(64)) bus ();

  cacheline_adaptor #(
    .LINE_W(256), .BURST_W(64), .ADDR_W(32), .OFFSET_W(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks completions and write beats against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_o) begin
        chk("resp_expected", 256'(exp_q.size() != 0), 256'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_address_o", 256'(bus.address_o), 256'(e.addr));
          chk("done_line_o", bus.line_o, e.line);
          chk("done_req_low", 256'({bus.read_o, bus.write_o}), 256'd0);
        end
      end
      if (bus.write_o) begin
        chk("wr_beat_expected", 256'(beat_q.size() != 0), 256'd1);
        if (beat_q.size() != 0) begin
          chk("burst_o", 256'(bus.burst_o), 256'(beat_q[0]));
          if (bus.resp_i) void'(beat_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_txn(input int len);
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk($sformatf("resp_after_%0d_cycles", len + 1), 256'(bus.resp_o), 256'd1);
    step();
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    @(negedge clk);
    chk("resp_single_cycle", 256'(bus.resp_o), 256'd0);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                          input logic [15:0] pat, input int len, input bit both);
    int k;
    logic [31:0] aligned;
    aligned = addr & ~32'h1f;
    exp_q.push_back('{addr: aligned, line: line});
    last_rd_line  = line;
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    bus.write_i   = both;
    bus.line_i    = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    step();
    k = 0;
    for (int i = 0; i < len; i++) begin
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? line[k*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[i]) k++;
      @(negedge clk);
      chk("rd_read_o_high", 256'({bus.read_o, bus.write_o}), 256'd2);
      chk("rd_address_o", 256'(bus.address_o), 256'(aligned));
      step();
    end
    finish_txn(len);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int len);
    logic [31:0] aligned;
    aligned = addr & ~32'h1f;
    exp_q.push_back('{addr: aligned, line: last_rd_line});
    for (int k = 0; k < 4; k++) beat_q.push_back(line[k*64 +: 64]);
    bus.address_i = addr;
    bus.write_i   = 1'b1;
    bus.read_i    = 1'b0;
    bus.line_i    = line;
    step();
    bus.line_i = '0;
    for (int i = 0; i < len; i++) begin
      bus.resp_i  = pat[i];
      bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      chk("wr_write_o_high", 256'({bus.read_o, bus.write_o}), 256'd1);
      step();
    end
    finish_txn(len);
    chk("wr_all_beats_retired", 256'(beat_q.size()), 256'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_no_request", 256'({bus.read_o, bus.write_o, bus.resp_o}), 256'd0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    last_rd_line  = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 256'({bus.read_o, bus.write_o, bus.resp_o}), 256'd0);
    chk("reset_line_o", bus.line_o, '0);
    chk("reset_address_o", 256'(bus.address_o), 256'd0);
    chk("reset_burst_o", 256'(bus.burst_o), 256'd0);
    step();

    // Read with continuous beats
    run_read(32'h0000_1234,
             {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
             16'b1111, 4, 1'b0);
    idle(2);

    // Write with gaps: strobes 1,0,1,0,0,1,1
    run_write(32'h0000_205F,
              {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
               64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
              16'b110_0101, 7);
    idle(2);

    // Back-to-back read then write, no idle gap inserted by the arbiter
    run_read(32'h8000_00FF,
             {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
              64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000},
             16'b1111, 4, 1'b0);
    run_write(32'h0000_0040,
              {64'hC3C3_0303_0303_0303, 64'hC2C2_0202_0202_0202,
               64'hC1C1_0101_0101_0101, 64'hC0C0_0000_0000_0000},
              16'b1111, 4);
    idle(5);

    // Asynchronous reset after two read beats
    bus.address_i = 32'h0000_3000;
    bus.read_i    = 1'b1;
    step();
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h5555_5555_5555_5555;
    step();
    bus.burst_i = 64'h6666_6666_6666_6666;
    step();
    bus.burst_i = 64'h7777_7777_7777_7777;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 256'({bus.read_o, bus.write_o, bus.resp_o}), 256'd0);
    chk("async_rst_line_o", bus.line_o, '0);
    chk("async_rst_address_o", 256'(bus.address_o), 256'd0);
    bus.read_i   = 1'b0;
    bus.resp_i   = 1'b0;
    last_rd_line = '0;
    step();
    step();
    rst = 1'b0;
    step();
    run_read(32'h0000_3008,
             {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
              64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A},
             16'b1111, 4, 1'b0);
    idle(2);

    // Stray memory strobes while idle, then a read with one gap
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hFFFF_0000_FFFF_0000;
    idle(3);
    bus.resp_i  = 1'b0;
    run_read(32'h0001_0010,
             {64'h9876_5432_1000_0003, 64'h9876_5432_1000_0002,
              64'h9876_5432_1000_0001, 64'h9876_5432_1000_0000},
             16'b1_1011, 5, 1'b0);
    idle(2);

    // Simultaneous read and write: the read wins
    run_read(32'h0000_0080,
             {64'hEEEE_0000_0000_0004, 64'hEEEE_0000_0000_0003,
              64'hEEEE_0000_0000_0002, 64'hEEEE_0000_0000_0001},
             16'b1111, 4, 1'b1);
    idle(3);

    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Memory-side responder behind the i-cache/d-cache arbiter.
- Accepts one whole-cacheline read or write from the arbiter (line side) and converts it into a 4-beat burst transaction on the physical memory port (burst side).
- On a read, reassembles the 4 returned beats into one line; on a write, serialises the line into 4 beats.
- Signals completion back to the arbiter with a single-cycle resp_o.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits.
- ADDR_W, 32, address width.
- OFFSET_W, 5, byte-offset bits cleared on the outgoing address (log2(LINE_W/8)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- address_i  input  ADDR_W  line address from arbiter.
- read_i  input  1  line read request; held high until resp_o.
- write_i  input  1  line write request; held high until resp_o.
- line_i  input  LINE_W  write data from arbiter.
- line_o  output  LINE_W  assembled read line.
- resp_o  output  1  one-cycle completion pulse to arbiter.
- address_o  output  ADDR_W  burst address to memory, line-aligned.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- burst_o  output  BURST_W  current write beat.
- burst_i  input  BURST_W  returned read beat.
- resp_i  input  1  memory beat strobe; each high cycle = one beat transferred.

Behaviour:
- Reset values: all outputs 0, state IDLE, beat counter 0, line buffer 0. Reset is asynchronous.
- Reset asserted mid-burst aborts the transaction immediately, with no resp_o. Memory is expected to be reset by the same signal.
- BEATS = LINE_W/BURST_W = 4. The 2-bit beat counter wraps 3->0 on the final beat.
- State IDLE:
  - read_i=1 -> RD_BURST. Latch address_o = {address_i[ADDR_W-1:OFFSET_W], OFFSET_W'b0}.
  - else write_i=1 -> WR_BURST. Latch the same aligned address and latch line_i into the line buffer.
  - If read_i and write_i are both 1, read wins; this case is illegal at system level and an assertion flags it.
- State RD_BURST:
  - read_o=1 (registered; high from the first cycle in the state).
  - Each cycle with resp_i=1: line_buf[cnt*BURST_W +: BURST_W] <= burst_i; cnt++.
  - Cycles with resp_i=0 are gaps: no capture, no count.
  - The capture of beat 3 moves to DONE.
- State WR_BURST:
  - write_o=1; burst_o = line_buf[cnt*BURST_W +: BURST_W], driven combinationally from the counter.
  - Each cycle with resp_i=1 retires the current beat; cnt++.
  - Beat 3 accepted -> DONE.
- State DONE:
  - resp_o=1 for exactly one cycle; read_o and write_o return to 0.
  - line_o = line_buf, and stays stable until the next read's DONE. Write transactions do not disturb line_o's captured read value.
  - Unconditional transition to IDLE.
  - read_i/write_i are ignored in DONE. The arbiter must drop its request on the edge that ends the resp_o cycle.
- Latency: with resp_i continuous, resp_o rises 1 (issue) + 4 (beats) = 5 cycles after the request is sampled in IDLE. Each resp_i gap adds one cycle.
- resp_i high in IDLE or DONE is ignored, with no counter change.
- address_o holds its value from request through DONE.

Decomposition:
- Shared package cacheline_adaptor_types:
  - state enum: IDLE, RD_BURST, WR_BURST, DONE.
  - localparams BEATS, CNT_W.
- No sub-module is needed. The FSM, counter and line buffer stay in one module, targeting about 150 lines.

Test Plan:
- Read, continuous resp_i: address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, read_o high 4 cycles, resp_o pulses cycle 5, line_o = {0x44..,0x33..,0x22..,0x11..}.
- Write with gaps: line_i = {D3,D2,D1,D0}, resp_i pattern 1,0,1,0,0,1,1 -> burst_o presents D0,D1,D1,D2,D2,D2,D3 in those cycles; write_o drops and resp_o pulses once after the 7th cycle; line_o unchanged.
- Back-to-back: read then write with the request dropped exactly after resp_o -> second burst's read_o/write_o rises in the cycle after IDLE; no spurious third transaction; counter restarts at 0.
- Reset mid-read after 2 beats: assert rst asynchronously -> read_o, resp_o, line_o go 0 with no clock edge; the next read completes correctly from beat 0.
- Stray resp_i in IDLE for 3 cycles, then read -> the first 3 strobes are ignored, and all 4 captured beats come from RD_BURST only.
- Simultaneous read_i and write_i -> read burst executes and the assertion fires.
